// File: rtl/reg_flit_packetizer.sv
// Reads registers FIRST_REG..FIRST_REG+cnt-1 through a dedicated read port and emits them as a flit packet.
// Optional feature: define NI_TX_CHECKSUM_EN to append an XOR checksum flit after the register words.
//
// state | meaning
// IDLE  | waiting for start; the flit register holds nothing valid
// HEAD  | head flit presented, waiting for its handshake
// BODY  | register word (or checksum) flit presented, waiting for its handshake
module reg_flit_packetizer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEST_W    = 4,
  parameter int FIRST_REG = 1,
  parameter int MAX_WORDS = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DEST_W-1:0] i_dest,
  input  logic [2:0]        i_count,
  output logic [ADDR_W-1:0] o_reg_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  output logic [DATA_W+1:0] o_flit_out,
  output logic              o_flit_valid,
  input  logic              i_flit_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] T_HEAD      = 2'b10;
  localparam logic [1:0] T_BODY      = 2'b00;
  localparam logic [1:0] T_TAIL      = 2'b11;
  localparam logic [1:0] T_HEAD_TAIL = 2'b01;
  localparam logic [2:0] MAX_CNT     = 3'(MAX_WORDS);
  localparam logic [2:0] LAST_IDX    = 3'(MAX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t              r_state, w_state_n;
  logic [DATA_W+1:0]   r_flit_out, w_flit_n;
  logic                r_flit_valid, w_valid_n;
  logic                r_busy, w_busy_n;
  logic                r_done, w_done_n;
  logic [2:0]          r_ptr, w_ptr_n;
  logic [2:0]          r_cnt, w_cnt_n;
  logic [2:0]          w_cnt_clamp;
  logic [2:0]          w_addr_idx;
  logic                w_hs;
  logic                w_is_tail;
  logic [1:0]          w_word_type;
`ifdef NI_TX_CHECKSUM_EN
  logic [DATA_W-1:0]   r_csum, w_csum_n;
`endif

  assign w_cnt_clamp = (i_count > MAX_CNT) ? MAX_CNT : i_count;
  // ptr reaches cnt after the last load; clamp so the read port never leaves r1..r7
  assign w_addr_idx  = (r_ptr > LAST_IDX) ? LAST_IDX : r_ptr;
  assign o_reg_addr  = ADDR_W'(FIRST_REG) + {{(ADDR_W-3){1'b0}}, w_addr_idx};
  assign w_hs        = r_flit_valid & i_flit_ready;
  assign w_is_tail   = (r_flit_out[DATA_W+1:DATA_W] == T_TAIL);
`ifdef NI_TX_CHECKSUM_EN
  assign w_word_type = T_BODY;
`else
  assign w_word_type = ((r_ptr + 3'd1) == r_cnt) ? T_TAIL : T_BODY;
`endif

  always_comb begin
    w_state_n = r_state;
    w_flit_n  = r_flit_out;
    w_valid_n = r_flit_valid;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
`ifdef NI_TX_CHECKSUM_EN
    w_csum_n  = r_csum;
`endif
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_cnt_n   = w_cnt_clamp;
          w_valid_n = 1'b1;
          w_busy_n  = 1'b1;
          w_ptr_n   = 3'd0;
          w_state_n = HEAD;
`ifdef NI_TX_CHECKSUM_EN
          w_csum_n  = '0;
          w_flit_n  = {T_HEAD, i_dest, w_cnt_clamp, {(DATA_W-DEST_W-3){1'b0}}};
`else
          w_flit_n  = {(w_cnt_clamp == 3'd0) ? T_HEAD_TAIL : T_HEAD,
                       i_dest, w_cnt_clamp, {(DATA_W-DEST_W-3){1'b0}}};
`endif
        end
      end
      HEAD: begin
        if (w_hs) begin
          if (r_cnt == 3'd0) begin
`ifdef NI_TX_CHECKSUM_EN
            w_flit_n  = {T_TAIL, {DATA_W{1'b0}}};
            w_state_n = BODY;
`else
            w_valid_n = 1'b0;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
            w_state_n = IDLE;
`endif
          end else begin
            w_flit_n  = {w_word_type, i_reg_data};
            w_ptr_n   = r_ptr + 3'd1;
            w_state_n = BODY;
`ifdef NI_TX_CHECKSUM_EN
            w_csum_n  = r_csum ^ i_reg_data;
`endif
          end
        end
      end
      BODY: begin
        if (w_hs) begin
          if (w_is_tail) begin
            w_valid_n = 1'b0;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
            w_ptr_n   = 3'd0;
            w_state_n = IDLE;
          end else if (r_ptr != r_cnt) begin
            w_flit_n = {w_word_type, i_reg_data};
            w_ptr_n  = r_ptr + 3'd1;
`ifdef NI_TX_CHECKSUM_EN
            w_csum_n = r_csum ^ i_reg_data;
          end else begin
            w_flit_n = {T_TAIL, r_csum};
`endif
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_flit_out   <= '0;
      r_flit_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ptr        <= 3'd0;
      r_cnt        <= 3'd0;
`ifdef NI_TX_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_state_n;
      r_flit_out   <= w_flit_n;
      r_flit_valid <= w_valid_n;
      r_busy       <= w_busy_n;
      r_done       <= w_done_n;
      r_ptr        <= w_ptr_n;
      r_cnt        <= w_cnt_n;
`ifdef NI_TX_CHECKSUM_EN
      r_csum       <= w_csum_n;
`endif
    end
  end

  assign o_flit_out   = r_flit_out;
  assign o_flit_valid = r_flit_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
